div_unit: RTL

Parametrised iterative integer divider for the M-extension execute stage, successor to the fixed 32-bit divider wrapper. Performs DIV, DIVU, REM and REMU on XLEN-bit operands with a radix-2 restoring datapath owned by this block. Results follow RISC-V sign, divide-by-zero and overflow rules, and a busy/done handshake tells the pipeline when to stall. Divide-by-zero and signed overflow take a one-cycle early exit.

---
 rtl/div_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with busy/done handshake.
// Divide-by-zero and signed overflow bypass the iteration loop and finish one cycle after go.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            go,
    input  logic [1:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(XLEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              sel_rem_q, sel_rem_d;
    logic [XLEN-1:0]   rd_q, rd_d;

    // Operand decode at the accepting edge
    logic              is_signed;
    logic              sign1, sign2;
    logic [XLEN-1:0]   abs1, abs2;
    logic              div_zero, overflow;
    logic [XLEN-1:0]   min_val;

    // One restoring iteration
    logic [XLEN:0]     r_shift;
    logic              q_bit;
    logic [XLEN:0]     r_next;

    // Sign-corrected results
    logic [XLEN-1:0]   quo_fix, rem_fix;

    logic              accept;

    always_comb begin
        is_signed = ~func3[0];
        sign1     = is_signed & rs1[XLEN-1];
        sign2     = is_signed & rs2[XLEN-1];
        abs1      = sign1 ? (~rs1 + 1'b1) : rs1;
        abs2      = sign2 ? (~rs2 + 1'b1) : rs2;
        min_val   = {1'b1, {(XLEN-1){1'b0}}};
        div_zero  = (rs2 == '0);
        overflow  = is_signed && (rs1 == min_val) && (&rs2);
    end

    always_comb begin
        r_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        q_bit   = (r_shift >= {1'b0, dvsr_q});
        r_next  = q_bit ? (r_shift - {1'b0, dvsr_q}) : r_shift;
    end

    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
    end

    // go is taken whenever the unit is not busy, which allows back-to-back issue
    // on the edge where done falls.
    assign accept = go && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;
        rd_d      = rd_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    sel_rem_d = func3[1];
                    cnt_d     = CntLoad;
                    dvsr_d    = abs2;
                    if (div_zero || overflow) begin
                        // Special results are parked un-negated and written by StFix.
                        quo_d     = div_zero ? '1 : rs1;
                        rem_d     = div_zero ? {1'b0, rs1} : '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFix;
                    end else begin
                        quo_d     = abs1;
                        rem_d     = '0;
                        neg_quo_d = sign1 ^ sign2;
                        neg_rem_d = sign1;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                quo_d = {quo_q[XLEN-2:0], q_bit};
                rem_d = r_next;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                rd_d    = sel_rem_q ? rem_fix : quo_fix;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
            rd_q      <= rd_d;
        end
    end

    assign busy = (state_q == StCalc) || (state_q == StFix);
    assign done = (state_q == StDone);
    assign rd   = rd_q;

endmodule
